// File: rtl/nn_fixed_pkg.sv
// Fixed-point defaults, saturation helper and trainer FSM state shared by the
// output-layer training datapath.
package nn_fixed_pkg;

  localparam int NN_W    = 10;
  localparam int NN_FRAC = 8;
  localparam int NN_ONE  = 1 << NN_FRAC;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELTA = 3'd1,
    ST_READ  = 3'd2,
    ST_UPD   = 3'd3,
    ST_DONE  = 3'd4
  } trainer_state_e;

  // Clamp x to the range of a w-bit two's complement value.
  function automatic int sat_signed(input int x, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/nn_neuron_delta.sv
// Combinational output-neuron delta: (actual-cal) * cal*(1-cal), in fixed point,
// saturated to the signed data width.
module nn_neuron_delta
  import nn_fixed_pkg::*;
#(
  parameter int W    = NN_W,
  parameter int FRAC = NN_FRAC
) (
  input  logic [W-1:0] actual,
  input  logic [W-1:0] cal,
  output logic [W-1:0] delta
);

  localparam int ONE_L = 1 << FRAC;

  int err;
  int sp;
  int d;

  always_comb begin
    err = int'(actual) - int'(cal);
    // Sigmoid slope is meaningless above 1.0, so it is forced to zero there.
    sp = 0;
    if (int'(cal) <= ONE_L) sp = (int'(cal) * (ONE_L - int'(cal))) >>> FRAC;
    d = sat_signed((err * sp) >>> FRAC, W);
    delta = d[W-1:0];
  end

endmodule

// File: rtl/output_layer_trainer.sv
// Sequential output-layer trainer: computes one delta per output neuron, then
// sweeps the weight RAM read/modify/write applying the scaled delta*hidden update.
module output_layer_trainer
  import nn_fixed_pkg::*;
#(
  parameter int N_OUT    = 3,
  parameter int N_HID    = 5,
  parameter int W        = NN_W,
  parameter int FRAC     = NN_FRAC,
  parameter int LR_SHIFT = 2,
  parameter int AW       = 7,
  parameter int W_BASE   = 50
) (
  input  logic               Clock,
  input  logic               Rst,
  input  logic               start,
  input  logic               WE,
  input  logic [N_OUT*W-1:0] actual,
  input  logic [N_OUT*W-1:0] cal,
  input  logic [N_HID*W-1:0] hid,
  output logic               busy,
  output logic               done,
  output logic [N_OUT*W-1:0] delta,
  output logic [AW-1:0]      w_addr,
  input  logic [W-1:0]       w_rd_data,
  output logic               w_wr_en,
  output logic [W-1:0]       w_wr_data,
  output logic [2:0]         state_dbg
);

  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;

  trainer_state_e     state;
  logic [KW-1:0]      k;
  logic [JW-1:0]      j;
  logic               we_l;
  logic [N_OUT*W-1:0] delta_r;
  logic [W-1:0]       nd_delta;
  logic [W-1:0]       w_new;
  int                 dw_i;
  int                 wn_i;

  nn_neuron_delta #(.W(W), .FRAC(FRAC)) u_delta (
    .actual (actual[k*W +: W]),
    .cal    (cal[k*W +: W]),
    .delta  (nd_delta)
  );

  always_comb begin
    dw_i  = (int'($signed(delta_r[k*W +: W])) * int'(hid[j*W +: W])) >>> (FRAC + LR_SHIFT);
    wn_i  = sat_signed(int'($signed(w_rd_data)) + dw_i, W);
    w_new = wn_i[W-1:0];
  end

  // Write strobe is decoded from state so an async reset drops it immediately
  // and it always lines up with the address presented in the UPD cycle.
  assign w_wr_en   = (state == ST_UPD) && we_l;
  assign w_wr_data = (state == ST_UPD) ? w_new : '0;
  assign delta     = delta_r;
  assign state_dbg = state;

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      j       <= '0;
      we_l    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      delta_r <= '0;
      w_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            we_l  <= WE;
            k     <= '0;
            busy  <= 1'b1;
            state <= ST_DELTA;
          end
        end
        ST_DELTA: begin
          delta_r[k*W +: W] <= nd_delta;
          if (k == KW'(N_OUT - 1)) begin
            k      <= '0;
            j      <= '0;
            w_addr <= AW'(W_BASE);
            state  <= ST_READ;
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_READ: state <= ST_UPD;
        ST_UPD: begin
          // Weights are contiguous (k-major, j inner), so the address just increments.
          w_addr <= w_addr + AW'(1);
          state  <= ST_READ;
          if (j == JW'(N_HID - 1)) begin
            j <= '0;
            if (k == KW'(N_OUT - 1)) state <= ST_DONE;
            else k <= k + KW'(1);
          end else begin
            j <= j + JW'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_layer_trainer.sv
// Bench for output_layer_trainer: directed table, random steps against an
// integer reference model, plus restart-ignore and mid-step reset sequences.
module tb_output_layer_trainer;

  localparam int W = 10, N_OUT = 3, N_HID = 5, AW = 7, W_BASE = 50;

  logic               Clock = 1'b0;
  logic               Rst;
  logic               start;
  logic               WE;
  logic [N_OUT*W-1:0] actual;
  logic [N_OUT*W-1:0] cal;
  logic [N_HID*W-1:0] hid;
  logic               busy;
  logic               done;
  logic [N_OUT*W-1:0] delta;
  logic [AW-1:0]      w_addr;
  logic [W-1:0]       w_rd_data;
  logic               w_wr_en;
  logic [W-1:0]       w_wr_data;
  logic [2:0]         state_dbg;

  int checks = 0;
  int errors = 0;

  logic [AW+W-1:0] exp_q[$];
  logic [AW+W-1:0] obs_q[$];

  logic [W-1:0] ram     [0:127];
  logic [W-1:0] pre_ram [0:127];
  logic         load_req;

  typedef struct {
    logic [N_OUT*W-1:0] actual;
    logic [N_OUT*W-1:0] cal;
    logic [N_HID*W-1:0] hid;
    logic               we;
    int                 w_init;
    int                 pulse_at;
    int                 exp_d0;
    int                 exp_w00;
  } vec_t;

  vec_t vecs[7];

  // clock/reset block
  always #5 Clock = ~Clock;

  output_layer_trainer dut (
    .Clock     (Clock),
    .Rst       (Rst),
    .start     (start),
    .WE        (WE),
    .actual    (actual),
    .cal       (cal),
    .hid       (hid),
    .busy      (busy),
    .done      (done),
    .delta     (delta),
    .w_addr    (w_addr),
    .w_rd_data (w_rd_data),
    .w_wr_en   (w_wr_en),
    .w_wr_data (w_wr_data),
    .state_dbg (state_dbg)
  );

  // Synchronous weight RAM with one-cycle read latency.
  always @(posedge Clock) begin
    if (load_req) begin
      for (int i = 0; i < 128; i++) ram[i] <= pre_ram[i];
    end else if (w_wr_en) begin
      ram[w_addr] <= w_wr_data;
    end
    w_rd_data <= ram[w_addr];
  end

  always @(negedge Clock) begin
    if (w_wr_en) obs_q.push_back({w_addr, w_wr_data});
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model
  function automatic int floor_div(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic int clamp(input int x);
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  function automatic int ref_delta(input int a, input int c);
    int sp;
    sp = (c > 256) ? 0 : (c * (256 - c)) / 256;
    return clamp(floor_div((a - c) * sp, 256));
  endfunction

  function automatic vec_t mk(input int a0, input int c0, input int ar, input int cr,
                              input int hv, input logic we, input int wi, input int pa,
                              input int ed, input int ew);
    vec_t v;
    for (int i = 0; i < N_OUT; i++) begin
      v.actual[i*W +: W] = W'((i == 0) ? a0 : ar);
      v.cal[i*W +: W]    = W'((i == 0) ? c0 : cr);
    end
    for (int i = 0; i < N_HID; i++) v.hid[i*W +: W] = W'(hv);
    v.we = we; v.w_init = wi; v.pulse_at = pa; v.exp_d0 = ed; v.exp_w00 = ew;
    return v;
  endfunction

  // driver tasks
  task automatic load_ram(input int fixed_val, input logic rnd);
    for (int i = 0; i < 128; i++)
      pre_ram[i] = rnd ? W'($urandom_range(1023, 0)) : W'(fixed_val);
    @(negedge Clock) load_req = 1'b1;
    @(negedge Clock) load_req = 1'b0;
  endtask

  task automatic start_step(input logic [N_OUT*W-1:0] a, input logic [N_OUT*W-1:0] c,
                            input logic [N_HID*W-1:0] h, input logic we_in);
    actual = a; cal = c; hid = h; WE = we_in;
    @(negedge Clock) start = 1'b1;
    @(negedge Clock) start = 1'b0;
  endtask

  task automatic run_step(input logic [N_OUT*W-1:0] a, input logic [N_OUT*W-1:0] c,
                          input logic [N_HID*W-1:0] h, input logic we_in, input int pulse_at);
    int ed[N_OUT];
    int cyc;
    int base;
    int n;
    for (int kk = 0; kk < N_OUT; kk++) begin
      ed[kk] = ref_delta(int'(a[kk*W +: W]), int'(c[kk*W +: W]));
      for (int jj = 0; jj < N_HID; jj++) begin
        int addr;
        int nw;
        addr = W_BASE + kk * N_HID + jj;
        nw = clamp(int'($signed(ram[addr])) + floor_div(ed[kk] * int'(h[jj*W +: W]), 1024));
        if (we_in) exp_q.push_back({AW'(addr), W'(nw)});
      end
    end
    base = obs_q.size();
    start_step(a, c, h, we_in);
    cyc = 0;
    while (cyc < 60) begin
      @(negedge Clock);
      cyc++;
      start = (cyc == pulse_at);
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (done) break;
    end
    start = 1'b0;
    chk("done_latency", cyc, 34);
    @(negedge Clock);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    for (int kk = 0; kk < N_OUT; kk++)
      chk($sformatf("delta%0d", kk), int'($signed(delta[kk*W +: W])), ed[kk]);
    n = obs_q.size() - base;
    chk("write_count", n, we_in ? N_OUT * N_HID : 0);
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("write%0d", i), int'(obs_q[base + i]), int'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    logic [N_OUT*W-1:0] ra;
    logic [N_OUT*W-1:0] rc;
    logic [N_HID*W-1:0] rh;
    Rst = 1'b0; start = 1'b0; WE = 1'b0; load_req = 1'b0;
    actual = '0; cal = '0; hid = '0;

    vecs[0] = mk(256, 128,   0,   0, 256, 1'b1,  100, -1,  32,  108);
    vecs[1] = mk(200, 200, 150, 150, 256, 1'b1,   77, -1,   0,   77);
    vecs[2] = mk(256, 128,   0,   0, 256, 1'b1,  511, -1,  32,  511);
    vecs[3] = mk(  0, 128,   0,   0, 256, 1'b1, -512, -1, -32, -512);
    vecs[4] = mk(256, 128,   0,   0, 256, 1'b0,  100, -1,  32,  100);
    vecs[5] = mk(256, 128,   0,   0, 256, 1'b1,  100, 10,  32,  108);
    vecs[6] = mk(  0, 300,   0,   0, 256, 1'b1,   50, -1,   0,   50);

    repeat (3) @(negedge Clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", w_wr_en, 0);
    chk("rst_delta", int'(delta), 0);
    chk("rst_addr", int'(w_addr), 0);
    chk("rst_wr_data", int'(w_wr_data), 0);
    chk("rst_state", int'(state_dbg), 0);
    @(negedge Clock) Rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      load_ram(vecs[v].w_init, 1'b0);
      run_step(vecs[v].actual, vecs[v].cal, vecs[v].hid, vecs[v].we, vecs[v].pulse_at);
      chk($sformatf("vec%0d_delta0", v), int'($signed(delta[W-1:0])), vecs[v].exp_d0);
      chk($sformatf("vec%0d_w00", v), int'($signed(ram[W_BASE])), vecs[v].exp_w00);
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N_OUT; i++) begin
        ra[i*W +: W] = W'($urandom_range(1023, 0));
        rc[i*W +: W] = W'($urandom_range(300, 0));
      end
      for (int i = 0; i < N_HID; i++) rh[i*W +: W] = W'($urandom_range(1023, 0));
      load_ram(0, 1'b1);
      run_step(ra, rc, rh, 1'($urandom_range(1, 0)), -1);
    end

    // Mid-step reset: everything clears in the same cycle, then a clean step.
    load_ram(100, 1'b0);
    start_step(vecs[0].actual, vecs[0].cal, vecs[0].hid, 1'b1);
    repeat (19) @(negedge Clock);
    #2 Rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", w_wr_en, 0);
    chk("abort_delta", int'(delta), 0);
    chk("abort_state", int'(state_dbg), 0);
    @(negedge Clock) Rst = 1'b1;
    run_step(vecs[0].actual, vecs[0].cal, vecs[0].hid, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
